// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache and the dcache.
// Data accesses win over instruction fetches. A saturating starvation
// counter forces an ifetch grant after STARVE_MAX consecutive dcache
// completions. The grant is registered. RAM drive is combinational from
// the granted requester, so an abort or reset drops the enables at once.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX_C = CW'(STARVE_MAX);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic d_req;
  assign d_req = dREN | dWEN;

  // Read data is a pass-through; callers qualify it with their wait.
  assign iload = ramload;
  assign dload = ramload;

  // Grant state and starvation counter registers, reset has priority.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next-state, starvation bookkeeping and RAM/wait drive for the grant.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case statement leaves a latch behind.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    iwait        = 1'b1;
    dwait        = 1'b1;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    ram_err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!iREN) starve_cnt_d = '0;
        if (d_req && !(iREN && (starve_cnt_q == STARVE_MAX_C))) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end

      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;   // a write wins over a read
        if (!d_req) begin
          // Aborted: enables are already low, wait stays high.
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
          if (iREN && (starve_cnt_q != STARVE_MAX_C))
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else if (ramstate == RS_ERROR) begin
          ram_err = 1'b1;
        end
      end

      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          iwait        = 1'b0;
          state_d      = IDLE;
          starve_cnt_d = '0;
        end else if (ramstate == RS_ERROR) begin
          ram_err = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset overrides the drive in the same cycle it is asserted.
    if (RST) begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      ram_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Directed scenarios push the
// expected completion (requester, RAM address, load data) into a queue;
// a negedge monitor pops and compares whenever a wait drops.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  err_pulses = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [31:0] addr,
                      input logic [31:0] data);
    sb_t e;
    e.is_d = is_d;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: compares each completion against the queue head.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ram_err) err_pulses++;
      if (!iwait || !dwait) begin
        check("one_done", 32'(iwait | dwait), 32'd1);
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_req_is_d", 32'(!dwait), 32'(e.is_d));
          check("sb_addr", ramaddr, e.addr);
          check("sb_load", e.is_d ? dload : iload, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dcnt;
    bit  idone;

    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h40; daddr = 32'h100; dstore = 32'h0;
    ramload = 32'h0; ramstate = FREE;

    // ---- Reset with both requests asserted ----
    repeat (2) begin
      @(negedge CLK);
      check("rst_iwait", 32'(iwait), 32'd1);
      check("rst_dwait", 32'(dwait), 32'd1);
      check("rst_ramREN", 32'(ramREN), 32'd0);
      check("rst_ramWEN", 32'(ramWEN), 32'd0);
      check("rst_ramaddr", ramaddr, 32'h0);
    end
    cyc();
    RST = 1'b0;                       // IDLE, both requesting
    @(negedge CLK);
    check("idle_ramREN", 32'(ramREN), 32'd0);
    cyc();                            // first grant must be dcache
    ramstate = BUSY; ramload = 32'h1111_1111;
    @(negedge CLK);
    check("first_dgnt_ren", 32'(ramREN), 32'd1);
    check("first_dgnt_addr", ramaddr, 32'h100);
    check("first_dgnt_iwait", 32'(iwait), 32'd1);
    push(1'b1, 32'h100, 32'h1111_1111);
    cyc();
    ramstate = ACCESS;
    @(negedge CLK);
    cyc();                            // IDLE bubble, ifetch still pending
    dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    check("bubble_ren", 32'(ramREN), 32'd0);

    // ---- Single ifetch, ACCESS on 3rd grant cycle ----
    cyc();
    ramstate = BUSY; ramload = 32'h8C01_0004;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("if_ren", 32'(ramREN), 32'd1);
      check("if_addr", ramaddr, 32'h40);
      check("if_iwait_busy", 32'(iwait), 32'd1);
      cyc();
    end
    ramstate = ACCESS;
    push(1'b0, 32'h40, 32'h8C01_0004);
    @(negedge CLK);
    check("if_iwait_done", 32'(iwait), 32'd0);
    check("if_iload", iload, 32'h8C01_0004);
    check("if_starve_clr", 32'(dut.starve_cnt_q), 32'd1); // before edge
    cyc();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    check("if_iwait_after", 32'(iwait), 32'd1);
    check("if_ren_after", 32'(ramREN), 32'd0);
    check("if_starve_zero", 32'(dut.starve_cnt_q), 32'd0);

    // ---- Contention: write (with read also set) beats ifetch ----
    cyc();
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; dREN = 1'b1;
    daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    cyc();
    ramstate = ACCESS; ramload = 32'h1234_5678;
    push(1'b1, 32'h80, 32'h1234_5678);
    @(negedge CLK);
    check("ct_wen", 32'(ramWEN), 32'd1);
    check("ct_ren_write_wins", 32'(ramREN), 32'd0);
    check("ct_store", ramstore, 32'hDEAD_BEEF);
    check("ct_dwait", 32'(dwait), 32'd0);
    cyc();
    dWEN = 1'b0; dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    check("ct_bubble_ren", 32'(ramREN), 32'd0);
    check("ct_bubble_wen", 32'(ramWEN), 32'd0);
    check("ct_bubble_iwait", 32'(iwait), 32'd1);
    cyc();
    ramstate = ACCESS; ramload = 32'h5555_AAAA;
    push(1'b0, 32'h44, 32'h5555_AAAA);
    @(negedge CLK);
    check("ct_igrant_ren", 32'(ramREN), 32'd1);
    check("ct_igrant_store", ramstore, 32'h0);
    cyc();
    iREN = 1'b0; ramstate = FREE;

    // ---- Starvation: dcache hammers, ifetch must get through ----
    cyc();
    iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h300;
    ramstate = ACCESS; ramload = 32'hA5A5_0000;
    repeat (4) push(1'b1, 32'h300, 32'hA5A5_0000);
    push(1'b0, 32'h400, 32'hA5A5_0000);
    dcnt = 0; idone = 1'b0;
    for (int k = 0; k < 40 && !idone; k++) begin
      @(negedge CLK);
      if (!dwait) dcnt++;
      if (!iwait) idone = 1'b1;
      cyc();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    check("starve_igrant", 32'(idone), 32'd1);
    check("starve_dcount", 32'(dcnt), 32'd4);
    @(negedge CLK);
    check("starve_cnt_zero", 32'(dut.starve_cnt_q), 32'd0);

    // ---- Abort in 2nd DGNT cycle, pending ifetch follows ----
    cyc();
    iREN = 1'b1; iaddr = 32'h600; dREN = 1'b1; daddr = 32'h500;
    ramstate = BUSY;
    cyc();
    @(negedge CLK);
    check("ab_ren_c1", 32'(ramREN), 32'd1);
    cyc();
    dREN = 1'b0;
    @(negedge CLK);
    check("ab_ren_drop", 32'(ramREN), 32'd0);
    check("ab_dwait", 32'(dwait), 32'd1);
    cyc();
    @(negedge CLK);
    check("ab_idle_ren", 32'(ramREN), 32'd0);
    check("ab_idle_dwait", 32'(dwait), 32'd1);
    cyc();
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    push(1'b0, 32'h600, 32'h0BAD_F00D);
    @(negedge CLK);
    check("ab_igrant_addr", ramaddr, 32'h600);
    cyc();
    iREN = 1'b0; ramstate = FREE;

    // ---- ERROR for one cycle, then ACCESS, during IGNT ----
    cyc();
    iREN = 1'b1; iaddr = 32'h700;
    cyc();
    ramstate = ERROR;
    @(negedge CLK);
    check("er_err", 32'(ram_err), 32'd1);
    check("er_iwait", 32'(iwait), 32'd1);
    check("er_ren_held", 32'(ramREN), 32'd1);
    cyc();
    ramstate = ACCESS; ramload = 32'hC0FF_EE00;
    push(1'b0, 32'h700, 32'hC0FF_EE00);
    @(negedge CLK);
    check("er_err_clear", 32'(ram_err), 32'd0);
    check("er_iwait_done", 32'(iwait), 32'd0);
    cyc();
    iREN = 1'b0; ramstate = FREE;

    // ---- Reset asserted mid-grant ----
    cyc();
    dREN = 1'b1; daddr = 32'h900; ramstate = BUSY;
    cyc();
    @(negedge CLK);
    check("mr_ren_before", 32'(ramREN), 32'd1);
    cyc();
    RST = 1'b1;
    @(negedge CLK);
    check("mr_ren_same", 32'(ramREN), 32'd0);
    check("mr_addr_same", ramaddr, 32'h0);
    cyc();
    RST = 1'b0; dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    check("mr_idle_ren", 32'(ramREN), 32'd0);
    check("mr_idle_dwait", 32'(dwait), 32'd1);

    repeat (2) cyc();
    check("err_pulses", 32'(err_pulses), 32'd1);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
